// File: rtl/pc_unit_if.sv
// Fetch/redirect/trap signal bundle for pc_unit.
// master: the PC unit itself; slave: fetch plus execute/CSR logic.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_fetch_ready;
  logic             i_redirect_valid;
  logic [WIDTH-1:0] i_redirect_target;
  logic             i_trap;
  logic             i_mret;
  logic [WIDTH-1:0] o_pc;
  logic             o_pc_valid;
  logic [WIDTH-1:0] o_epc;
  logic             o_misaligned;
  logic [WIDTH-1:0] o_bad_addr;

  modport master (
    input  i_fetch_ready, i_redirect_valid, i_redirect_target, i_trap, i_mret,
    output o_pc, o_pc_valid, o_epc, o_misaligned, o_bad_addr
  );

  modport slave (
    output i_fetch_ready, i_redirect_valid, i_redirect_target, i_trap, i_mret,
    input  o_pc, o_pc_valid, o_epc, o_misaligned, o_bad_addr
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: boot delay, fetch handshake, redirect with alignment
// check, trap entry with EPC capture and mret.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned      BOOT_DELAY   = 2,
  parameter int unsigned      IALIGN       = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_unit_if.master bus
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  logic [0:0]       r_state;
  logic [3:0]       r_boot_cnt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_misaligned;
  logic [WIDTH-1:0] r_bad_addr;
  logic             w_misaligned;

  // Only the low bits matter; the +4 path is never checked.
  assign w_misaligned = (IALIGN == 16) ? bus.i_redirect_target[0]
                                       : |bus.i_redirect_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BOOT;
      r_boot_cnt   <= '0;
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_misaligned <= 1'b0;
      r_bad_addr   <= '0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_boot_cnt <= r_boot_cnt + 4'd1;
          if (r_boot_cnt == BOOT_LAST) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.i_trap) begin
            r_epc <= r_pc;
            r_pc  <= TRAP_VECTOR;
          end else if (bus.i_mret) begin
            r_pc <= r_epc;
          end else if (bus.i_redirect_valid) begin
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
              r_bad_addr   <= bus.i_redirect_target;
            end else begin
              r_pc <= bus.i_redirect_target;
            end
          end else if (bus.i_fetch_ready) begin
            r_pc <= r_pc + WIDTH'(4);
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign bus.o_pc         = r_pc;
  assign bus.o_pc_valid   = (r_state == ST_RUN);
  assign bus.o_epc        = r_epc;
  assign bus.o_misaligned = r_misaligned;
  assign bus.o_bad_addr   = r_bad_addr;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit. It generates the fetch address for the RV32I front end and adds several features:
- programmable reset vector and boot delay;
- a valid/ready fetch handshake;
- branch/jump redirect with a misalignment check;
- trap entry, with the exception PC captured, and trap return (mret).

It sits between the fetch stage (consumer of o_pc) and the execute/CSR logic (sources of redirect, trap and mret).

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
BOOT_DELAY, 2, cycles after reset release before o_pc_valid asserts (1..15)
IALIGN, 32, instruction alignment in bits: 32 checks target[1:0]==0, 16 checks target[0]==0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_fetch_ready  in  1  fetch accepted o_pc this cycle
i_redirect_valid  in  1  branch/jump taken
i_redirect_target  in  WIDTH  branch/jump destination
i_trap  in  1  trap request
i_mret  in  1  return from trap
o_pc  out  WIDTH  current fetch address
o_pc_valid  out  1  o_pc is presentable to fetch
o_epc  out  WIDTH  PC captured on last trap
o_misaligned  out  1  one-cycle pulse: redirect target misaligned
o_bad_addr  out  WIDTH  last misaligned target

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low (rst_n). Assertion takes effect immediately; release is sampled on clk.
- Reset values:
  - o_pc = RESET_VECTOR
  - o_pc_valid = 0, o_epc = 0, o_misaligned = 0, o_bad_addr = 0
  - FSM = BOOT, boot counter = 0
- FSM states:
  - BOOT: o_pc_valid = 0; all inputs ignored; counter increments each cycle. When counter == BOOT_DELAY-1, go to RUN; o_pc_valid is 1 from the next cycle.
  - RUN: o_pc_valid = 1. No return to BOOT except by reset.
- RUN update priority (evaluated each rising edge, one per cycle; all outputs registered, 1-cycle latency):
  1. i_trap: o_epc <= o_pc; o_pc <= TRAP_VECTOR.
  2. i_mret: o_pc <= o_epc.
  3. i_redirect_valid with an aligned target: o_pc <= i_redirect_target.
  4. i_redirect_valid with a misaligned target: o_pc holds; o_misaligned <= 1 for exactly one cycle; o_bad_addr <= target.
  5. i_fetch_ready: o_pc <= o_pc + 4.
  6. Otherwise: hold (stall).
- Simultaneous events: higher priority wins; lower-priority inputs that cycle are dropped, not queued.
  - Redirect overrides increment even when i_fetch_ready = 1.
  - i_trap with i_mret: trap wins; o_epc takes the current o_pc.
- Arithmetic:
  - Increment is always +4, modulo 2^WIDTH. 0xFFFF_FFFC + 4 wraps to 0 with no flag.
  - Alignment check uses only the low bits; the increment path is never checked.
- o_misaligned is 0 in every cycle other than the pulse. Back-to-back misaligned redirects give back-to-back pulses, and o_bad_addr updates each time.
- o_pc is stable while o_pc_valid = 1 and i_fetch_ready = 0, unless a redirect, trap or mret occurs.
- Reset mid-operation: immediate return to the reset values and BOOT; o_epc is cleared.
- All registers are WIDTH bits; o_epc and o_bad_addr are sized to WIDTH.

Test Plan:
- Boot sequence: release rst_n with BOOT_DELAY=2 -> o_pc_valid=0 for 2 cycles, then 1; o_pc=RESET_VECTOR throughout.
- Sequential fetch: i_fetch_ready=1 for 4 cycles from 0x0 -> o_pc 0x4, 0x8, 0xC, 0x10. Deassert ready -> o_pc holds 0x10.
- Aligned redirect: at o_pc=0x10, i_redirect_valid=1, target=0x200, ready=1 -> o_pc=0x200 next cycle, not 0x14. Target=0x202 with IALIGN=32 -> o_pc holds, o_misaligned pulses 1 cycle, o_bad_addr=0x202. With IALIGN=16 the same target is accepted.
- Trap and return: at o_pc=0x200, i_trap=1 together with i_redirect_valid=1 -> o_pc=0x100 (TRAP_VECTOR), o_epc=0x200. Later i_mret=1 -> o_pc=0x200.
- Wrap-around: redirect to 0xFFFF_FFFC, then ready=1 -> o_pc=0x0000_0000.
- Async reset: assert rst_n=0 between clock edges during RUN -> o_pc=RESET_VECTOR and o_pc_valid=0 immediately, o_epc=0; the boot sequence repeats on release.
